// File: rtl/codec_i2c_target_pkg.sv
// Shared constants for the codec control-port I2C target.
// Holds the FSM state encodings, default bus address and special register indices.
`timescale 1ns/1ps
package codec_i2c_target_pkg;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
  localparam int         NUM_REGS_DEFAULT = 16;
  localparam logic [3:0] RESET_REG_IDX    = 4'd15;
  localparam logic [3:0] ACTIVE_REG_IDX   = 4'd9;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ADDR     = 3'd1;
  localparam state_t ST_ADDR_ACK = 3'd2;
  localparam state_t ST_REG      = 3'd3;
  localparam state_t ST_REG_ACK  = 3'd4;
  localparam state_t ST_DATA     = 3'd5;
  localparam state_t ST_DATA_ACK = 3'd6;
  localparam state_t ST_IGNORE   = 3'd7;

endpackage

// File: rtl/codec_i2c_target_line_sync.sv
// Two-flop synchronizer for one I2C line plus rise/fall detection
// against a one-clock delayed copy of the synchronized level.
`timescale 1ns/1ps
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // Idle bus is high, so reset to 1 to avoid a false edge after reset.
  logic [2:0] pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe <= 3'b111;
    else          pipe <= {pipe[1:0], pin};
  end

  assign level = pipe[1];
  assign rise  = pipe[1] & ~pipe[2];
  assign fall  = ~pipe[1] & pipe[2];

endmodule

// File: rtl/codec_i2c_target.sv
// Write-only I2C target standing in for the codec control port: decodes
// address/register/data frames, ACKs them and commits into a 16x9 register file.
`timescale 1ns/1ps
module codec_i2c_target
  import codec_i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_clk,
  inout  wire        i2c_data,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       active,
  output logic       err
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       byte_full;
  logic       extra_byte;
  logic [6:0] reg_idx;
  logic       data_msb;
  logic       sda_oe;
  logic [8:0] regs [NUM_REGS];

  i2c_line_sync u_scl_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (i2c_clk),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (i2c_data),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  // An SCL edge in the same cycle wins, so a simultaneous SDA change is data.
  assign start_det = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop_det  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;

  assign i2c_data = sda_oe ? 1'b0 : 1'bz;
  assign rd_data  = regs[rd_addr];
  assign active   = regs[ACTIVE_REG_IDX][0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      byte_full  <= 1'b0;
      extra_byte <= 1'b0;
      reg_idx    <= 7'd0;
      data_msb   <= 1'b0;
      sda_oe     <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 7'd0;
      wr_data    <= 9'd0;
      err        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
    end else begin
      wr_en <= 1'b0;
      if (start_det) begin
        state      <= ST_ADDR;
        bit_cnt    <= 3'd0;
        byte_full  <= 1'b0;
        extra_byte <= 1'b0;
        sda_oe     <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        byte_full <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_REG, ST_DATA: begin
            if (scl_rise && !byte_full) begin
              shreg   <= {shreg[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end else if (scl_fall && byte_full) begin
              // The SCL fall ending the 8th bit decides ACK/NACK for the byte.
              byte_full <= 1'b0;
              case (state)
                ST_ADDR: begin
                  if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                    state  <= ST_ADDR_ACK;
                    sda_oe <= 1'b1;
                  end else begin
                    state <= ST_IGNORE;
                    err   <= 1'b1;
                  end
                end
                ST_REG: begin
                  reg_idx  <= shreg[7:1];
                  data_msb <= shreg[0];
                  state    <= ST_REG_ACK;
                  sda_oe   <= 1'b1;
                end
                default: begin
                  if (extra_byte) begin
                    state <= ST_IGNORE;
                    err   <= 1'b1;
                  end else begin
                    state  <= ST_DATA_ACK;
                    sda_oe <= 1'b1;
                    if (reg_idx == {3'b000, RESET_REG_IDX}) begin
                      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 9'd0;
                      err     <= 1'b0;
                      wr_en   <= 1'b1;
                      wr_addr <= reg_idx;
                      wr_data <= {data_msb, shreg};
                    end else if (int'(reg_idx) < NUM_REGS) begin
                      regs[reg_idx[3:0]] <= {data_msb, shreg};
                      wr_en   <= 1'b1;
                      wr_addr <= reg_idx;
                      wr_data <= {data_msb, shreg};
                    end else begin
                      err <= 1'b1;
                    end
                  end
                end
              endcase
            end
          end
          ST_ADDR_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= ST_REG;
          end
          ST_REG_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= ST_DATA;
          end
          ST_DATA_ACK: if (scl_fall) begin
            sda_oe     <= 1'b0;
            extra_byte <= 1'b1;
            state      <= ST_DATA;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codec_i2c_target.sv
// Scoreboard bench for codec_i2c_target: bit-banged I2C master, expected
// register writes queued at stimulus time and popped on every wr_en pulse.
`timescale 1ns/1ps
module tb_codec_i2c_target;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  wire        sda_bus;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic [8:0] rd_data;
  logic       active;
  logic       err;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_w;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #10 clk = ~clk;

  codec_i2c_target dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i2c_clk  (scl),
    .i2c_data (sda_bus),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .active   (active),
    .err      (err)
  );

  // Every commit must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      wr_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          miscompares++;
          $display("[TB] FAIL write_value: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   wr_addr, wr_data, exp_w[15:9], exp_w[8:0]);
        end
      end
    end
  end

  task automatic i2c_start();
    sda_low = 1'b0;
    #Q;
    scl = 1'b1;
    #(2*Q);
    sda_low = 1'b1;
    #(2*Q);
    scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    #Q;
    scl = 1'b1;
    #(2*Q);
    sda_low = 1'b0;
    #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = !b;
    #Q;
    scl = 1'b1;
    #(2*Q);
    scl = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_low = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;
    acked = (sda_bus === 1'b0);
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d,
                             output logic [2:0] acks);
    i2c_start();
    send_byte(a, acks[2]);
    send_byte(r, acks[1]);
    send_byte(d, acks[0]);
    i2c_stop();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if ({wr_en, wr_addr, wr_data, err, active} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %0h, expected 0", {wr_en, wr_addr, wr_data, err, active});
    end
    vectors++;
    if (sda_bus !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_sda: got %b, expected released (1)", sda_bus);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      vectors++;
      if (rd_data !== 9'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_reg%0d: got %0h, expected 0", i, rd_data);
      end
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_config();
    logic [2:0] acks;
    logic [3:0] idx [4];
    logic [8:0] val [4];
    int cnt0;
    cnt0 = wr_count;
    idx = '{4'd7, 4'd4, 4'd2, 4'd9};
    val = '{9'h0C2, 9'h038, 9'h079, 9'h001};
    exp_q.push_back({7'd7, 9'h0C2});
    write_frame(8'h34, 8'h0E, 8'hC2, acks);
    vectors++;
    if (acks !== 3'b111) begin miscompares++; $display("[TB] FAIL cfg_ack0: got %b, expected 111", acks); end
    exp_q.push_back({7'd4, 9'h038});
    write_frame(8'h34, 8'h08, 8'h38, acks);
    vectors++;
    if (acks !== 3'b111) begin miscompares++; $display("[TB] FAIL cfg_ack1: got %b, expected 111", acks); end
    exp_q.push_back({7'd2, 9'h079});
    write_frame(8'h34, 8'h04, 8'h79, acks);
    vectors++;
    if (acks !== 3'b111) begin miscompares++; $display("[TB] FAIL cfg_ack2: got %b, expected 111", acks); end
    exp_q.push_back({7'd9, 9'h001});
    write_frame(8'h34, 8'h12, 8'h01, acks);
    vectors++;
    if (acks !== 3'b111) begin miscompares++; $display("[TB] FAIL cfg_ack3: got %b, expected 111", acks); end
    for (int i = 0; i < 4; i++) begin
      rd_addr = idx[i];
      @(negedge clk);
      vectors++;
      if (rd_data !== val[i]) begin
        miscompares++;
        $display("[TB] FAIL cfg_reg%0d: got %0h, expected %0h", idx[i], rd_data, val[i]);
      end
    end
    vectors++;
    if (active !== 1'b1) begin miscompares++; $display("[TB] FAIL cfg_active: got %b, expected 1", active); end
    vectors++;
    if (wr_count - cnt0 != 4) begin
      miscompares++;
      $display("[TB] FAIL cfg_wr_count: got %0d, expected 4", wr_count - cnt0);
    end
  endtask

  task automatic test_wrong_addr();
    logic [2:0] acks;
    int cnt0;
    cnt0 = wr_count;
    write_frame(8'h36, 8'h0E, 8'hC2, acks);
    vectors++;
    if (acks[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL waddr_nack: got ack=%b, expected 0", acks[2]); end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL waddr_err: got %b, expected 1", err); end
    rd_addr = 4'd7;
    @(negedge clk);
    vectors++;
    if (rd_data !== 9'h0C2) begin miscompares++; $display("[TB] FAIL waddr_reg7: got %0h, expected 0c2", rd_data); end
    vectors++;
    if (wr_count != cnt0) begin miscompares++; $display("[TB] FAIL waddr_no_write: got %0d writes, expected 0", wr_count - cnt0); end
  endtask

  task automatic test_reg_reset();
    logic [2:0] acks;
    exp_q.push_back({7'd15, 9'h000});
    write_frame(8'h34, 8'h1E, 8'h00, acks);
    vectors++;
    if (acks !== 3'b111) begin miscompares++; $display("[TB] FAIL rreset_ack: got %b, expected 111", acks); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      vectors++;
      if (rd_data !== 9'd0) begin
        miscompares++;
        $display("[TB] FAIL rreset_reg%0d: got %0h, expected 0", i, rd_data);
      end
    end
    vectors++;
    if (active !== 1'b0) begin miscompares++; $display("[TB] FAIL rreset_active: got %b, expected 0", active); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rreset_err: got %b, expected 0", err); end
  endtask

  task automatic test_read_req();
    logic a0, a1;
    i2c_start();
    send_byte(8'h35, a0);
    send_byte(8'h0E, a1);
    vectors++;
    if (a0 !== 1'b0) begin miscompares++; $display("[TB] FAIL read_nack: got ack=%b, expected 0", a0); end
    vectors++;
    if (a1 !== 1'b0) begin miscompares++; $display("[TB] FAIL read_ignore: got ack=%b, expected 0", a1); end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL read_err: got %b, expected 1", err); end
    i2c_stop();
  endtask

  task automatic test_aborted();
    logic a0, a1, a2, a3, a4;
    int cnt0;
    cnt0 = wr_count;
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h0E, a1);
    i2c_stop();
    vectors++;
    if (wr_count != cnt0) begin miscompares++; $display("[TB] FAIL abort_stop_write: got %0d writes, expected 0", wr_count - cnt0); end
    i2c_start();
    send_byte(8'h34, a0);
    send_byte(8'h0E, a1);
    exp_q.push_back({7'd8, 9'h000});
    i2c_start();
    send_byte(8'h34, a2);
    send_byte(8'h10, a3);
    send_byte(8'h00, a4);
    i2c_stop();
    vectors++;
    if ({a2, a3, a4} !== 3'b111) begin miscompares++; $display("[TB] FAIL abort_rs_ack: got %b, expected 111", {a2, a3, a4}); end
    vectors++;
    if (wr_count - cnt0 != 1) begin miscompares++; $display("[TB] FAIL abort_rs_writes: got %0d, expected 1", wr_count - cnt0); end
    rd_addr = 4'd7;
    @(negedge clk);
    vectors++;
    if (rd_data !== 9'd0) begin miscompares++; $display("[TB] FAIL abort_reg7: got %0h, expected 0", rd_data); end
  endtask

  task automatic test_reset_mid_ack();
    logic [2:0] acks;
    logic [7:0] b;
    b = 8'h34;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_low = 1'b0;
    #Q;
    vectors++;
    if (sda_bus !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ack_drive: got %b, expected 0", sda_bus); end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (sda_bus !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_ack_release: got %b, expected released (1)", sda_bus); end
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ack_err: got %b, expected 0", err); end
    i2c_stop();
    exp_q.push_back({7'd7, 9'h0C2});
    write_frame(8'h34, 8'h0E, 8'hC2, acks);
    vectors++;
    if (acks !== 3'b111) begin miscompares++; $display("[TB] FAIL mid_ack_next_ack: got %b, expected 111", acks); end
    rd_addr = 4'd7;
    @(negedge clk);
    vectors++;
    if (rd_data !== 9'h0C2) begin miscompares++; $display("[TB] FAIL mid_ack_reg7: got %0h, expected 0c2", rd_data); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_wrong_addr();
    test_reg_reset();
    test_read_req();
    test_aborted();
    test_reset_mid_ack();
    repeat (10) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
